watch_display_scanner: RTL and testbench

Consumer side of the watch time counters. Takes the binary hour/minute/second values those counters produce and drives a six-digit, common-anode, multiplexed 7-segment display. Latches a coherent snapshot once per scan frame, inserts anti-ghosting dead time, and blinks the field being edited. Sits between the timekeeping/edit counters and the board display pins.

---
 rtl/watch_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 28 ++
 rtl/watch_display_scanner.sv | 154 +++++++++++++++
 tb/tb_watch_display_scanner.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared encodings for the watch datapath: edit modes, active-low segment
// patterns for a {g,f,e,d,c,b,a} common-anode digit, and digit slot indices.
package watch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'b00,
    MODE_EDIT_H = 2'b01,
    MODE_EDIT_M = 2'b10,
    MODE_EDIT_S = 2'b11
  } mode_t;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [2:0] IDX_H_TENS  = 3'd0;
  localparam logic [2:0] IDX_H_UNITS = 3'd1;
  localparam logic [2:0] IDX_M_TENS  = 3'd2;
  localparam logic [2:0] IDX_M_UNITS = 3'd3;
  localparam logic [2:0] IDX_S_TENS  = 3'd4;
  localparam logic [2:0] IDX_S_UNITS = 3'd5;

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern. Codes 10-14 are blank and
// code 15 is the dash used for out-of-range fields.
module seg7_decode
  import watch_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      4'd15:   seg = SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/watch_display_scanner.sv
// Six-digit multiplexed display driver for the watch: per-frame snapshot of
// h:m:s, anti-ghosting dead time per slot, and blinking of the edited field.
module watch_display_scanner
  import watch_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int DEAD_CYCLES = 1_000,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] mode,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [BLK_W-1:0] blk_cnt;
  logic             phase;
  mode_t            mode_q;
  logic [4:0]       sh_hours;
  logic [5:0]       sh_minutes;
  logic [5:0]       sh_seconds;

  logic       cnt_last;
  logic       dead;
  logic       mode_changed;
  logic [5:0] field_val;
  logic       field_ok;
  mode_t      field_mode;
  logic [3:0] tens_d;
  logic [3:0] units_d;
  logic [3:0] code;
  logic [6:0] seg_dig;
  logic       blank;

  // Divide by 10 for 0..63 using reciprocal multiply (205/2048).
  function automatic logic [3:0] div10(input logic [5:0] v);
    logic [13:0] p;
    p = 14'(v) * 14'd205;
    return 4'(p >> 11);
  endfunction

  assign cnt_last     = (cnt == CNT_LAST);
  assign dead         = (int'(cnt) < DEAD_CYCLES);
  assign mode_changed = (mode_t'(mode) != mode_q);

  always_comb begin
    field_val  = 6'd0;
    field_ok   = 1'b0;
    field_mode = MODE_RUN;
    case (idx)
      IDX_H_TENS, IDX_H_UNITS: begin
        field_val  = {1'b0, sh_hours};
        field_ok   = (sh_hours < 5'd24);
        field_mode = MODE_EDIT_H;
      end
      IDX_M_TENS, IDX_M_UNITS: begin
        field_val  = sh_minutes;
        field_ok   = (sh_minutes < 6'd60);
        field_mode = MODE_EDIT_M;
      end
      IDX_S_TENS, IDX_S_UNITS: begin
        field_val  = sh_seconds;
        field_ok   = (sh_seconds < 6'd60);
        field_mode = MODE_EDIT_S;
      end
      default: ;
    endcase
    tens_d  = div10(field_val);
    units_d = 4'(field_val - 6'(tens_d) * 6'd10);
    // Odd slots carry the units digit of their field.
    code    = !field_ok ? 4'hF : (idx[0] ? units_d : tens_d);
    blank   = phase && (mode_q != MODE_RUN) && (mode_q == field_mode);
  end

  seg7_decode u_seg7_decode (
    .code (code),
    .seg  (seg_dig)
  );

  // Slot/digit scan and frame snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= IDX_H_TENS;
      sh_hours   <= '0;
      sh_minutes <= '0;
      sh_seconds <= '0;
    end else begin
      if (cnt_last) begin
        cnt <= '0;
        if (idx == IDX_S_UNITS) begin
          idx        <= IDX_H_TENS;
          sh_hours   <= hours;
          sh_minutes <= minutes;
          sh_seconds <= seconds;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Blink timebase, restarted on any mode change
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt <= '0;
      phase   <= 1'b0;
      mode_q  <= MODE_RUN;
    end else begin
      mode_q <= mode_t'(mode);
      if (mode_changed) begin
        blk_cnt <= '0;
        phase   <= 1'b0;
      end else if (blk_cnt == BLK_LAST) begin
        blk_cnt <= '0;
        phase   <= ~phase;
      end else begin
        blk_cnt <= blk_cnt + BLK_W'(1);
      end
    end
  end

  // Registered display pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 6'b111111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else if (dead) begin
      an  <= 6'b111111;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(6'b000001 << idx);
      seg <= blank ? SEG_BLANK : seg_dig;
      dp  <= blank ? 1'b1 : !((idx == IDX_H_UNITS) || (idx == IDX_M_UNITS));
    end
  end

endmodule

// File: tb/tb_watch_display_scanner.sv
// Scoreboard bench for watch_display_scanner with small scan/blink constants.
module tb_watch_display_scanner;

  localparam int R = 4;
  localparam int D = 1;
  localparam int B = 8;
  localparam int LIM = 200;

  localparam logic [6:0] DIG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct packed {
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_vec;
  int n_err;
  exp_t exp_q[$];

  // Reference model state: m_t is the cycle position within the frame.
  int   m_t, m_h, m_m, m_s, m_bc;
  bit   m_ph;
  logic [1:0] m_pm;

  watch_display_scanner #(
    .REFRESH_DIV (R),
    .DEAD_CYCLES (D),
    .BLINK_DIV   (B)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .mode    (mode),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_h = 0; m_m = 0; m_s = 0; m_bc = 0; m_ph = 0; m_pm = 2'b00;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    int c, i, f, v, lim, dg;
    bit blk;
    c = m_t % R;
    i = m_t / R;
    if (c < D) begin
      e.an = 6'b111111; e.seg = 7'b1111111; e.dp = 1'b1;
      return e;
    end
    f   = i / 2;
    v   = (f == 0) ? m_h : (f == 1) ? m_m : m_s;
    lim = (f == 0) ? 24 : 60;
    e.an = 6'b111111;
    e.an[i] = 1'b0;
    if (v >= lim) e.seg = 7'b0111111;
    else begin
      dg = (i % 2 == 1) ? (v % 10) : (v / 10);
      e.seg = DIG[dg];
    end
    e.dp = !(i == 1 || i == 3);
    blk = m_ph && (m_pm != 2'b00) && (int'(m_pm) == f + 1);
    if (blk) begin
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
    end
    return e;
  endfunction

  task automatic model_update();
    if (m_t == 6 * R - 1) begin
      m_h = hours; m_m = minutes; m_s = seconds;
    end
    m_t = (m_t + 1) % (6 * R);
    if (mode != m_pm) begin
      m_bc = 0; m_ph = 0;
    end else if (m_bc == B - 1) begin
      m_bc = 0; m_ph = !m_ph;
    end else begin
      m_bc++;
    end
    m_pm = mode;
  endtask

  // One clock: predict, advance the model, then compare at the falling edge.
  task automatic step();
    exp_t e;
    exp_q.push_back(model_out());
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_eq("sb_nonempty", 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq("an", 32'(an), 32'(e.an));
      check_eq("seg", 32'(seg), 32'(e.seg));
      check_eq("dp", 32'(dp), 32'(e.dp));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic run_to_slot(input string tag, input int t_target);
    int k;
    for (k = 0; k < LIM && m_t != t_target; k++) step();
    check_eq(tag, 32'(m_t), 32'(t_target));
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0;
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56; mode = 2'b00;
    reset_n = 1'b1;
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_an", 32'(an), 32'h3f);
    check_eq("rst_seg", 32'(seg), 32'h7f);
    check_eq("rst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Frame 0 shows 00:00:00, then 12:34:56 after the first snapshot.
    run(60);

    // Seconds change during idx 2; current frame keeps 56.
    run_to_slot("wait_idx2", 2 * R + 1);
    seconds = 6'd57;
    run(40);

    // Out-of-range fields show dashes.
    minutes = 6'd60;
    run(30);
    hours = 5'd25; minutes = 6'd34; seconds = 6'd61;
    run(30);
    hours = 5'd23; minutes = 6'd59; seconds = 6'd0;
    run(30);

    // Edit minutes: blink.
    hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
    mode = 2'b10;
    run(50);
    for (k = 0; k < LIM && !m_ph; k++) step();
    check_eq("wait_phase1", 32'(m_ph), 32'd1);
    mode = 2'b11;
    run(40);

    // Edit hours briefly.
    mode = 2'b01;
    run(40);

    // Asynchronous reset mid-slot at idx 3.
    mode = 2'b00;
    run_to_slot("wait_idx3", 3 * R + 2);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_an", 32'(an), 32'h3f);
    check_eq("arst_seg", 32'(seg), 32'h7f);
    check_eq("arst_dp", 32'(dp), 32'h1);
    @(negedge clk);
    check_eq("arst_hold_an", 32'(an), 32'h3f);
    exp_q.delete();
    model_reset();
    reset_n = 1'b1;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
